// File: rtl/game_timer_ctrl.sv
// Game clock countdown: 1 Hz prescaler, IDLE/RUN/PAUSED/DONE sequencing, 10-bit seconds out.
// Optional time bonus enabled by defining TIMER_BONUS_EN.
module game_timer_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned START_SECS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       bonus,
  input  logic [6:0] bonus_secs,
  output logic [9:0] timer,
  output logic       running,
  output logic       paused,
  output logic       game_over,
  output logic       sec_tick
);
  localparam int unsigned   PW      = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TC      = PW'(CLK_HZ - 1);
  localparam logic [9:0]    START_V = 10'(START_SECS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t        state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [9:0]    timer_nx, timer_upd;
  logic          tick_nx, tc, dec;

  assign tc  = (presc == TC);
  // pause outranks the decrement, so a pause landing on terminal count defers it
  assign dec = (state == RUN) & ~clear & ~pause & tc;

`ifdef TIMER_BONUS_EN
  logic        add_en;
  logic [10:0] sum;
  assign add_en = ((state == RUN) | (state == PAUSED)) & ~clear & ~pause & bonus;
  always_comb begin
    sum       = {1'b0, timer} + {4'b0, bonus_secs & {7{add_en}}} - {10'b0, dec};
    timer_upd = (sum > 11'd999) ? 10'd999 : sum[9:0];
  end
`else
  logic unused_bonus;
  assign unused_bonus = ^{bonus, bonus_secs};
  assign timer_upd    = timer - {9'b0, dec};
`endif

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    timer_nx = timer;
    tick_nx  = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      presc_nx = '0;
      timer_nx = START_V;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_nx = RUN;
          presc_nx = '0;
        end
        RUN: if (pause) begin
          state_nx = PAUSED;
        end else begin
          presc_nx = tc ? '0 : presc + PW'(1);
          timer_nx = timer_upd;
          tick_nx  = dec;
          if (timer_upd == 10'd0) state_nx = DONE;
        end
        PAUSED: if (pause) state_nx = RUN;
                else       timer_nx = timer_upd;
        DONE: if (start) begin
          state_nx = RUN;
          presc_nx = '0;
          timer_nx = START_V;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      timer     <= START_V;
      sec_tick  <= 1'b0;
      running   <= 1'b0;
      paused    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      timer     <= timer_nx;
      sec_tick  <= tick_nx;
      running   <= (state_nx == RUN);
      paused    <= (state_nx == PAUSED);
      game_over <= (state_nx == DONE);
    end
  end
endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: directed scenarios plus a randomized run against a cycle model.
module tb_game_timer_ctrl;
  localparam int HZ = 4;
  localparam int SS = 3;
`ifdef TIMER_BONUS_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  logic clk = 0, rst = 0, start = 0, pause = 0, clear = 0, bonus = 0;
  logic [6:0] bonus_secs = '0;
  logic [9:0] timer, timer_b;
  logic running, paused, game_over, sec_tick;
  logic running_b, paused_b, game_over_b, sec_tick_b;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  game_timer_ctrl #(.CLK_HZ(HZ), .START_SECS(SS)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .bonus(bonus), .bonus_secs(bonus_secs), .timer(timer), .running(running),
    .paused(paused), .game_over(game_over), .sec_tick(sec_tick));

  game_timer_ctrl #(.CLK_HZ(HZ), .START_SECS(998)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
    .bonus(bonus), .bonus_secs(bonus_secs), .timer(timer_b), .running(running_b),
    .paused(paused_b), .game_over(game_over_b), .sec_tick(sec_tick_b));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #1;
    n_cmp++; if (timer !== 10'd3) begin n_bad++; $display("FAIL reset_timer got=%0d exp=3", timer); end
    n_cmp++; if ({running, paused, game_over, sec_tick} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags got=%b exp=0000", {running, paused, game_over, sec_tick}); end
    @(posedge clk); #1 rst = 0;
    step();
    n_cmp++; if (running !== 1'b0 || timer !== 10'd3) begin
      n_bad++; $display("FAIL reset_idle running=%b timer=%0d exp 0/3", running, timer); end
  endtask

  task automatic test_countdown();
    int ticks = 0;
    start = 1; step(); start = 0;
    n_cmp++; if (running !== 1'b1 || timer !== 10'd3) begin
      n_bad++; $display("FAIL start_run running=%b timer=%0d exp 1/3", running, timer); end
    for (int k = 1; k <= 14; k++) begin
      step();
      ticks += int'(sec_tick);
      if (k == 3) begin
        n_cmp++; if (timer !== 10'd3) begin n_bad++; $display("FAIL pre_tick got=%0d exp=3", timer); end
      end
      if (k == 4) begin
        n_cmp++; if (timer !== 10'd2 || sec_tick !== 1'b1) begin
          n_bad++; $display("FAIL edge4 timer=%0d tick=%b exp 2/1", timer, sec_tick); end
      end
      if (k == 8) begin
        n_cmp++; if (timer !== 10'd1) begin n_bad++; $display("FAIL edge8 got=%0d exp=1", timer); end
      end
      if (k == 12) begin
        n_cmp++; if (timer !== 10'd0 || game_over !== 1'b1 || running !== 1'b0) begin
          n_bad++; $display("FAIL edge12 timer=%0d go=%b run=%b exp 0/1/0", timer, game_over, running); end
      end
    end
    n_cmp++; if (ticks != 3) begin n_bad++; $display("FAIL tick_count got=%0d exp=3", ticks); end
  endtask

  task automatic test_done_restart();
    start = 1; step(); start = 0;
    n_cmp++; if (timer !== 10'd3 || game_over !== 1'b0 || running !== 1'b1) begin
      n_bad++; $display("FAIL restart timer=%0d go=%b run=%b exp 3/0/1", timer, game_over, running); end
    step(); step(); step();
    n_cmp++; if (timer !== 10'd3) begin n_bad++; $display("FAIL restart_hold got=%0d exp=3", timer); end
    step();
    n_cmp++; if (timer !== 10'd2) begin n_bad++; $display("FAIL restart_dec got=%0d exp=2", timer); end
  endtask

  task automatic test_pause();
    bit changed = 0;
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    step(); step();
    pause = 1; step(); pause = 0;
    n_cmp++; if (paused !== 1'b1 || running !== 1'b0) begin
      n_bad++; $display("FAIL pause_flags paused=%b run=%b exp 1/0", paused, running); end
    for (int k = 0; k < 10; k++) begin
      step();
      if (timer !== 10'd3 || paused !== 1'b1 || sec_tick !== 1'b0) changed = 1;
    end
    n_cmp++; if (changed) begin n_bad++; $display("FAIL pause_frozen got=changed exp=frozen timer=%0d", timer); end
    pause = 1; step(); pause = 0;
    n_cmp++; if (running !== 1'b1 || paused !== 1'b0) begin
      n_bad++; $display("FAIL resume run=%b paused=%b exp 1/0", running, paused); end
    step();
    n_cmp++; if (timer !== 10'd3) begin n_bad++; $display("FAIL resume_hold got=%0d exp=3", timer); end
    step();
    n_cmp++; if (timer !== 10'd2 || sec_tick !== 1'b1) begin
      n_bad++; $display("FAIL resume_dec timer=%0d tick=%b exp 2/1", timer, sec_tick); end
  endtask

  task automatic test_clear();
    clear = 1; step(); clear = 0;
    n_cmp++; if (running !== 1'b0 || timer !== 10'd3) begin
      n_bad++; $display("FAIL clear_run run=%b timer=%0d exp 0/3", running, timer); end
    start = 1; step(); start = 0; step();
    clear = 1; start = 1; step(); clear = 0; start = 0;
    for (int k = 0; k < 5; k++) step();
    n_cmp++; if (running !== 1'b0 || timer !== 10'd3) begin
      n_bad++; $display("FAIL clear_start run=%b timer=%0d exp 0/3", running, timer); end
  endtask

  task automatic test_bonus();
    logic [9:0] exp;
    start = 1; step(); start = 0;
    for (int k = 0; k < 4; k++) step();
    bonus = 1; bonus_secs = 7'd5; step(); bonus = 0;
    exp = BEN ? 10'd7 : 10'd2;
    n_cmp++; if (timer !== exp) begin n_bad++; $display("FAIL bonus_add got=%0d exp=%0d", timer, exp); end
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    for (int k = 1; k < 12; k++) step();
    bonus = 1; bonus_secs = 7'd4; step(); bonus = 0;
    exp = BEN ? 10'd4 : 10'd0;
    n_cmp++; if (timer !== exp || game_over !== !BEN || running !== BEN) begin
      n_bad++; $display("FAIL bonus_final timer=%0d go=%b run=%b exp %0d/%b/%b",
                        timer, game_over, running, exp, !BEN, BEN); end
    do_reset();
    start = 1; step(); start = 0;
    bonus = 1; bonus_secs = 7'd100; step(); bonus = 0;
    exp = BEN ? 10'd999 : 10'd998;
    n_cmp++; if (timer_b !== exp) begin n_bad++; $display("FAIL bonus_sat got=%0d exp=%0d", timer_b, exp); end
  endtask

  task automatic test_async_reset();
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    for (int k = 0; k < 10; k++) step();
    n_cmp++; if (timer !== 10'd1) begin n_bad++; $display("FAIL pre_rst got=%0d exp=1", timer); end
    #2 rst = 1;
    #1;
    n_cmp++; if (timer !== 10'd3 || {running, paused, game_over, sec_tick} !== 4'b0) begin
      n_bad++; $display("FAIL async_rst timer=%0d flags=%b exp 3/0000", timer, {running, paused, game_over, sec_tick}); end
    @(posedge clk); #1 rst = 0;
    for (int k = 0; k < 6; k++) step();
    n_cmp++; if (running !== 1'b0 || timer !== 10'd3) begin
      n_bad++; $display("FAIL post_rst_idle run=%b timer=%0d exp 0/3", running, timer); end
  endtask

  // Reference model: phase = cycles elapsed in the current second while counting.
  task automatic test_random();
    int ms, mt, ph, nt, prints;
    bit mtick;
    ms = 0; mt = SS; ph = 0; prints = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(7) == 0);
      pause = ($urandom_range(9) == 0);
      clear = ($urandom_range(59) == 0);
      bonus = ($urandom_range(9) == 0);
      bonus_secs = ($urandom_range(3) == 0) ? 7'd0 : 7'($urandom_range(127));
      step();
      mtick = 0;
      if (clear) begin
        ms = 0; mt = SS; ph = 0;
      end else if (ms == 0) begin
        if (start) begin ms = 1; ph = 0; end
      end else if (ms == 1) begin
        if (pause) ms = 2;
        else begin
          mtick = (ph == HZ - 1);
          ph = mtick ? 0 : ph + 1;
          nt = mt - int'(mtick) + ((BEN && bonus) ? int'(bonus_secs) : 0);
          mt = (nt > 999) ? 999 : nt;
          if (mt == 0) ms = 3;
        end
      end else if (ms == 2) begin
        if (pause) ms = 1;
        else if (BEN && bonus) mt = (mt + int'(bonus_secs) > 999) ? 999 : mt + int'(bonus_secs);
      end else begin
        if (start) begin ms = 1; mt = SS; ph = 0; end
      end
      n_cmp++;
      if (int'(timer) != mt || running !== (ms == 1) || paused !== (ms == 2) ||
          game_over !== (ms == 3) || sec_tick !== mtick) begin
        n_bad++;
        if (prints < 10) begin
          prints++;
          $display("FAIL random cyc=%0d timer=%0d run=%b pau=%b go=%b tick=%b exp %0d/%b/%b/%b/%b",
                   c, timer, running, paused, game_over, sec_tick, mt, ms == 1, ms == 2, ms == 3, mtick);
        end
      end
    end
    {start, pause, clear, bonus} = '0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_done_restart();
    test_pause();
    test_clear();
    test_bonus();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Countdown controller for the game clock. Produces the 10-bit seconds value that drives the three-digit seven-segment timer display. Sequences the start, pause, resume and game-over behaviour from a 1 Hz prescaler on the system clock. Optionally accepts time-bonus pulses from game logic.

## Interface
- CLK_HZ, 50_000_000: system clock cycles per second; prescaler terminal count is CLK_HZ-1; must be ≥ 2.
- START_SECS, 60: value loaded on reset, clear and start-from-DONE; legal range 1..999.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begin countdown.
- pause  input  1  one-cycle pulse; toggle RUN/PAUSED.
- clear  input  1  synchronous soft clear back to IDLE.
- bonus  input  1  one-cycle pulse; add bonus_secs (only with TIMER_BONUS_EN).
- bonus_secs  input  7  seconds to add, 0..127.
- timer  output  10  remaining seconds, 0..999; feeds the display decoder.
- running  output  1  high in RUN.
- paused  output  1  high in PAUSED.
- game_over  output  1  high in DONE.
- sec_tick  output  1  one-cycle pulse on each decrement.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Reset values (async, immediate): state IDLE, timer=START_SECS, prescaler=0, running=0, paused=0, game_over=0, sec_tick=0.
- Input priority in the same cycle: clear > start > pause > bonus/decrement.
- clear, any state → IDLE: timer=START_SECS, prescaler=0.
- IDLE:
  - start → RUN, prescaler=0.
  - pause and bonus ignored.
- RUN:
  - Prescaler counts 0..CLK_HZ-1 and wraps.
  - At terminal count: timer decrements and sec_tick=1 for one cycle.
  - Decrement taking timer from 1 to 0 → DONE.
  - pause → PAUSED; prescaler holds its value.
  - start ignored.
- PAUSED:
  - Prescaler and timer frozen.
  - pause → RUN; prescaler resumes from the held value, not from 0.
  - start ignored.
- DONE:
  - timer=0, game_over=1.
  - start → RUN: timer=START_SECS, prescaler=0, game_over=0.
  - pause and bonus ignored.
- Arithmetic: next timer = min(999, timer − dec + bonus_add), where dec and bonus_add are each 0 when inactive. Compute in 11 bits, then saturate; no wrap-around.
- Bonus coincident with the final decrement (timer=1, bonus_secs>0): timer becomes bonus_secs and the state stays RUN. If bonus_secs=0, → DONE.
- Bonus in PAUSED adds immediately; the state stays PAUSED.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- start/pause/clear take effect on the next rising edge; state flags update on that same edge.
- First decrement comes exactly CLK_HZ cycles after the edge that accepts start.
- timer and sec_tick update on the same edge; game_over rises on the edge where timer reaches 0.
- Bonus latency is 1 cycle.
- rst asserted mid-second clears all state without waiting for a clock edge. On release, the block sits in IDLE.

## Configuration
- TIMER_BONUS_EN defined: bonus and bonus_secs behave as above.
- TIMER_BONUS_EN undefined:
  - Ports remain present but are ignored.
  - Adder and saturation logic are removed.
  - Next timer = timer − dec.

## Test plan
Bench uses CLK_HZ=4, START_SECS=3.
- Reset then start pulse at edge 0 → running=1 after edge 0; timer=2 at edge 4, 1 at edge 8, 0 at edge 12 with game_over=1, running=0; sec_tick high for exactly 3 single cycles.
- Pause 2 cycles into a second, hold 10 cycles, pause again → timer unchanged while paused=1; next decrement exactly 2 cycles after resume.
- TIMER_BONUS_EN:
  - timer=2, bonus_secs=5 → 7 next edge.
  - timer=1, bonus_secs=4 on the tick edge → 4, no game_over.
  - START_SECS=998, bonus_secs=100 → 999.
- TIMER_BONUS_EN undefined: bonus pulse with bonus_secs=5 → timer unaffected.
- clear in RUN → IDLE, timer=3, running=0. clear and start in the same cycle → IDLE.
- rst asserted between edges while timer=1 → timer=3 and flags 0 immediately.
- In DONE, start → timer=3, game_over=0, running=1; next decrement 4 cycles later.
